rr_arbiter_4to1: RTL and testbench

Four-input round-robin arbiter with a one-entry output register. It sits directly upstream of the one-hot 4-way data mux stage. It accepts 32-bit words from four valid/ready producers and grants one per cycle with rotating priority. It presents the winner on a registered valid/ready output, together with the registered one-hot grant (`io_sel`), which downstream one-hot muxes consume unchanged.

---
 rtl/rr_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 44 ++++
 rtl/rr_arbiter_4to1.sv | 129 ++++++++++++
 tb/tb_rr_arbiter_4to1.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb_pkg
//  Description : Shared constants and helpers for the 4-to-1 round-robin
//                arbiter: requester count, pointer reset value, grant
//                counter width and a 4-bit rotate-left-by-one.
//  Revision    : 1.0  initial release
// ============================================================================
package rr_arb_pkg;

    localparam int         N_REQ     = 4;
    localparam logic [3:0] PTR_RESET = 4'b0001;
    localparam int         CNT_W     = 16;

    // Rotate a one-hot vector left by one; bit 3 wraps to bit 0.
    function automatic logic [3:0] rotl1(input logic [3:0] x);
        return {x[2:0], x[3]};
    endfunction

endpackage : rr_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Purely combinational circular priority picker. Returns the
//                first set bit of i_req found scanning upward from the
//                one-hot position in i_ptr, wrapping 3 -> 0.
//  Ports       : i_req   [3:0]  request vector
//                i_ptr   [3:0]  one-hot highest-priority position
//                o_grant [3:0]  one-hot grant, 0000 when i_req == 0
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant
);

    logic       w_found;
    logic [1:0] w_idx;

    // Outer loop locates the pointer position, inner loop walks the
    // requests from there. w_found stops any later hit from adding a bit,
    // so the result stays one-hot.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int s = 0; s < N_REQ; s++) begin
            if (i_ptr[s]) begin
                for (int k = 0; k < N_REQ; k++) begin
                    w_idx = 2'(s + k);
                    if (!w_found && i_req[w_idx]) begin
                        o_grant[w_idx] = 1'b1;
                        w_found        = 1'b1;
                    end
                end
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/rr_arbiter_4to1.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_4to1
//  Description : Four-input round-robin arbiter with a one-entry output
//                register. Grants one valid/ready producer per cycle with
//                rotating priority and presents the winner plus its
//                registered one-hot source select.
//  Ports       : clock, reset          clock / synchronous active-high reset
//                io_in_valid  [3:0]    producer offers
//                io_in_ready  [3:0]    producer word taken (one-hot or 0)
//                io_in0..3    [W-1:0]  producer data
//                io_out_valid          output register holds a word
//                io_out_ready          consumer takes the word
//                io_out_bits  [W-1:0]  buffered word
//                io_sel       [3:0]    one-hot source of buffered word
//                io_grant_cnt [15:0]   saturating grant counter
//  Options     : RR_ARB_GRANT_CNT_EN  enables the grant counter; when
//                undefined io_grant_cnt is tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter_4to1
    import rr_arb_pkg::*;
#(
    parameter int W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] io_in_valid,
    output logic [N_REQ-1:0] io_in_ready,
    input  logic [W-1:0]     io_in0,
    input  logic [W-1:0]     io_in1,
    input  logic [W-1:0]     io_in2,
    input  logic [W-1:0]     io_in3,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [W-1:0]     io_out_bits,
    output logic [N_REQ-1:0] io_sel,
    output logic [CNT_W-1:0] io_grant_cnt
);

    logic             r_full_q, w_full_d;
    logic [N_REQ-1:0] r_ptr_q,  w_ptr_d;
    logic [N_REQ-1:0] r_sel_q,  w_sel_d;
    logic [W-1:0]     r_data_q, w_data_d;

    logic             w_accept;
    logic             w_fire;
    logic [N_REQ-1:0] w_grant;
    logic [W-1:0]     w_mux;

    rr_pick u_pick (
        .i_req   (io_in_valid),
        .i_ptr   (r_ptr_q),
        .o_grant (w_grant)
    );

    // The buffer can take a new word when empty or when it drains this cycle.
    assign w_accept = !r_full_q || io_out_ready;
    assign w_fire   = w_accept && (|io_in_valid);

    // Reset gates the handshake so no producer sees a take during reset.
    assign io_in_ready = (w_accept && !reset) ? w_grant : '0;

    // One-hot AND-OR mux, same form the downstream stage uses.
    assign w_mux = ({W{w_grant[0]}} & io_in0) |
                   ({W{w_grant[1]}} & io_in1) |
                   ({W{w_grant[2]}} & io_in2) |
                   ({W{w_grant[3]}} & io_in3);

    always_comb begin
        w_full_d = r_full_q;
        w_ptr_d  = r_ptr_q;
        w_sel_d  = r_sel_q;
        w_data_d = r_data_q;
        if (w_fire) begin
            w_full_d = 1'b1;
            w_ptr_d  = rotl1(w_grant);
            w_sel_d  = w_grant;
            w_data_d = w_mux;
        end else if (w_accept) begin
            // Drained with nothing to refill; data register keeps its value.
            w_full_d = 1'b0;
            w_sel_d  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_full_q <= 1'b0;
            r_ptr_q  <= PTR_RESET;
            r_sel_q  <= '0;
            r_data_q <= '0;
        end else begin
            r_full_q <= w_full_d;
            r_ptr_q  <= w_ptr_d;
            r_sel_q  <= w_sel_d;
            r_data_q <= w_data_d;
        end
    end

    assign io_out_valid = r_full_q;
    assign io_out_bits  = r_data_q;
    assign io_sel       = r_sel_q;

`ifdef RR_ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] r_cnt_q, w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (w_fire && (r_cnt_q != {CNT_W{1'b1}})) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign io_grant_cnt = r_cnt_q;
`else
    assign io_grant_cnt = '0;
`endif

endmodule : rr_arbiter_4to1
`default_nettype wire

// File: tb/tb_rr_arbiter_4to1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter_4to1
//  Description : Self-checking bench for rr_arbiter_4to1. A behavioural
//                model (integer pointer, queue-free single-entry buffer)
//                is compared against the DUT every cycle, and directed
//                vectors carry hand-computed literal expectations.
//  Options     : RR_ARB_GRANT_CNT_EN  also exercises counter saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_arbiter_4to1;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  io_in_valid;
    logic [3:0]  io_in_ready;
    logic [31:0] din [4];
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] io_out_bits;
    logic [3:0]  io_sel;
    logic [15:0] io_grant_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    rr_arbiter_4to1 #(.W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in0       (din[0]),
        .io_in1       (din[1]),
        .io_in2       (din[2]),
        .io_in3       (din[3]),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_bits  (io_out_bits),
        .io_sel       (io_sel),
        .io_grant_cnt (io_grant_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_live = 0;
    bit          m_full;
    int          m_ptr;      // index of highest-priority requester
    int          m_src;      // index of buffered word's source, -1 if empty
    logic [31:0] m_data;
    int          m_cnt;

    function automatic int model_pick();
        for (int k = 0; k < 4; k++) begin
            if (io_in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clock) begin
        int g;
        if (reset) begin
            m_live = 1;
            m_full = 0;
            m_ptr  = 0;
            m_src  = -1;
            m_data = '0;
            m_cnt  = 0;
        end else if (m_live) begin
            g = model_pick();
            if (!m_full || io_out_ready) begin
                if (g >= 0) begin
                    m_data = din[g];
                    m_src  = g;
                    m_full = 1;
                    m_ptr  = (g + 1) % 4;
`ifdef RR_ARB_GRANT_CNT_EN
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
                end else begin
                    m_full = 0;
                    m_src  = -1;
                end
            end
        end
    end

    always @(negedge clock) begin
        int          g;
        logic [3:0]  er;
        logic [3:0]  es;
        if (m_live) begin
            g  = model_pick();
            er = 4'b0000;
            if (!reset && (!m_full || io_out_ready) && g >= 0) er = 4'b0001 << g;
            es = (m_src < 0) ? 4'b0000 : (4'b0001 << m_src);
            check("model_in_ready", 32'(io_in_ready), 32'(er));
            check("model_out_valid", 32'(io_out_valid), 32'(m_full));
            check("model_out_bits", io_out_bits, m_data);
            check("model_sel", 32'(io_sel), 32'(es));
            check("model_grant_cnt", 32'(io_grant_cnt), 32'(m_cnt));
        end
    end

    // ---------------- directed vectors ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [3:0] rr_exp [8];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        reset        = 1'b1;
        io_in_valid  = 4'b0000;
        io_out_ready = 1'b0;
        for (int k = 0; k < 4; k++) din[k] = '0;
        repeat (2) step();
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_out_valid", 32'(io_out_valid), 32'd0);
        check("rst_sel", 32'(io_sel), 32'd0);
        check("rst_bits", io_out_bits, 32'd0);
        check("rst_in_ready", 32'(io_in_ready), 32'd0);
        step();

        // All four requesting, consumer always ready: strict rotation, no bubbles
        io_in_valid  = 4'b1111;
        io_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) din[k] = 32'hD000_0000 + 32'(k);
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            check("rr_in_ready", 32'(io_in_ready), 32'(rr_exp[c]));
            if (c > 0) begin
                check("rr_out_valid", 32'(io_out_valid), 32'd1);
                check("rr_sel", 32'(io_sel), 32'(rr_exp[c-1]));
                check("rr_bits", io_out_bits, 32'hD000_0000 + 32'((c - 1) % 4));
            end
            step();
        end

        // Drain
        io_in_valid = 4'b0000;
        @(negedge clock);
        check("drain_valid", 32'(io_out_valid), 32'd1);
        step();

        // Single requester, consumer stalled: take once, then hold
        io_in_valid  = 4'b0100;
        din[2]       = 32'hA5A5_0002;
        io_out_ready = 1'b0;
        @(negedge clock);
        check("hold_first_ready", 32'(io_in_ready), 32'b0100);
        check("hold_first_valid", 32'(io_out_valid), 32'd0);
        step();
        repeat (3) begin
            @(negedge clock);
            check("hold_ready", 32'(io_in_ready), 32'd0);
            check("hold_valid", 32'(io_out_valid), 32'd1);
            check("hold_sel", 32'(io_sel), 32'b0100);
            check("hold_bits", io_out_bits, 32'hA5A5_0002);
            step();
        end

        // Drain; priority now sits at input 3
        io_in_valid  = 4'b0000;
        io_out_ready = 1'b1;
        step();

        // Grant input 1 -> priority moves to input 2
        io_in_valid = 4'b0010;
        din[1]      = 32'hB0B0_0001;
        @(negedge clock);
        check("ptr_g1", 32'(io_in_ready), 32'b0010);
        step();

        // Inputs 0 and 3 only: scan 2,3 -> input 3 wins, then input 0
        io_in_valid = 4'b1001;
        din[0]      = 32'hC0C0_0000;
        din[3]      = 32'hC0C0_0003;
        @(negedge clock);
        check("wrap_g3", 32'(io_in_ready), 32'b1000);
        step();
        @(negedge clock);
        check("wrap_g0", 32'(io_in_ready), 32'b0001);
        check("wrap_sel", 32'(io_sel), 32'b1000);
        check("wrap_bits", io_out_bits, 32'hC0C0_0003);
        step();

        // Full buffer, drain and fill on the same edge
        io_in_valid = 4'b0010;
        din[1]      = 32'hE0E0_0001;
        @(negedge clock);
        check("df_ready", 32'(io_in_ready), 32'b0010);
        check("df_valid_before", 32'(io_out_valid), 32'd1);
        check("df_sel_before", 32'(io_sel), 32'b0001);
        step();
        io_in_valid = 4'b0000;
        @(negedge clock);
        check("df_valid_after", 32'(io_out_valid), 32'd1);
        check("df_sel_after", 32'(io_sel), 32'b0010);
        check("df_bits_after", io_out_bits, 32'hE0E0_0001);
        #1;
        io_out_ready = 1'b0;

        // Reset while full and stalled
        step();
        reset       = 1'b1;
        io_in_valid = 4'b1111;
        @(negedge clock);
        check("rstf_in_ready", 32'(io_in_ready), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clock);
        check("rstf_valid", 32'(io_out_valid), 32'd0);
        check("rstf_sel", 32'(io_sel), 32'd0);
        check("rstf_bits", io_out_bits, 32'd0);
        check("rstf_ptr", 32'(io_in_ready), 32'b0001);

`ifdef RR_ARB_GRANT_CNT_EN
        // Saturation: run well past 0xFFFF grants
        check("cnt_after_rst", 32'(io_grant_cnt), 32'd0);
        io_out_ready = 1'b1;
        repeat (65540) step();
        @(negedge clock);
        check("cnt_sat", 32'(io_grant_cnt), 32'h0000_FFFF);
        repeat (3) step();
        @(negedge clock);
        check("cnt_sat_hold", 32'(io_grant_cnt), 32'h0000_FFFF);
`else
        io_out_ready = 1'b1;
        repeat (5) step();
        @(negedge clock);
        check("cnt_tied_zero", 32'(io_grant_cnt), 32'd0);
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rr_arbiter_4to1
`default_nettype wire
